// File: rtl/denoise_writeback_if.sv
// Handshake and SRAM write bus between the denoise output selector, the writeback
// block and the frame controller.
interface denoise_writeback_if #(
    parameter int BITWIDTH = 8,
    parameter int ADDR_W   = 10
);
    logic                  start;
    logic [ADDR_W-1:0]     base_addr;
    logic                  in_valid;
    logic                  in_ready;
    logic [BITWIDTH*9-1:0] denoise_block_out_0;
    logic [BITWIDTH*9-1:0] denoise_block_out_1;
    logic [BITWIDTH*9-1:0] denoise_block_out_2;
    logic [BITWIDTH*9-1:0] denoise_block_out_3;
    logic                  sram_we;
    logic [ADDR_W-1:0]     sram_addr;
    logic [BITWIDTH*4-1:0] sram_wdata;
    logic                  busy;
    logic                  frame_done;

    modport master (
        output start, base_addr, in_valid,
        output denoise_block_out_0, denoise_block_out_1,
        output denoise_block_out_2, denoise_block_out_3,
        input  in_ready, sram_we, sram_addr, sram_wdata, busy, frame_done
    );

    modport slave (
        input  start, base_addr, in_valid,
        input  denoise_block_out_0, denoise_block_out_1,
        input  denoise_block_out_2, denoise_block_out_3,
        output in_ready, sram_we, sram_addr, sram_wdata, busy, frame_done
    );
endinterface

// File: rtl/denoise_writeback.sv
// Serializes bundles of four denoised 3x3 blocks into nine packed SRAM writes each,
// counting bundles per frame and pulsing frame_done after the final write.
module denoise_writeback #(
    parameter int BITWIDTH   = 8,
    parameter int ADDR_W     = 10,
    parameter int NUM_BUNDLE = 64
) (
    input logic                clk,
    input logic                rst_n,
    denoise_writeback_if.slave bus
);
    localparam int CNT_W = $clog2(NUM_BUNDLE + 1);
    localparam int BLK_W = BITWIDTH * 9;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BUNDLE - 1);

    typedef enum logic [1:0] {IDLE, WAIT, WRITE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         pix_k;
    logic [CNT_W-1:0]   bundle_cnt;
    logic [ADDR_W-1:0]  addr_ptr;
    logic [BLK_W-1:0]   cap_0;
    logic [BLK_W-1:0]   cap_1;
    logic [BLK_W-1:0]   cap_2;
    logic [BLK_W-1:0]   cap_3;
    logic               ready;
    logic               handshake;
    logic               last_pix;
    logic               last_bundle;
    logic               done_pend;

    assign last_pix    = (pix_k == 4'd8);
    assign last_bundle = (bundle_cnt == LAST_CNT);
    assign handshake   = ready && bus.in_valid && !bus.start;
    assign bus.in_ready = ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ready is open in WAIT and on the last pixel of a non-final bundle so bundles can chain.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = WAIT;
            end
            WAIT: begin
                ready = 1'b1;
                if (bus.start)         state_nxt = WAIT;
                else if (bus.in_valid) state_nxt = WRITE;
            end
            WRITE: begin
                ready = last_pix && !last_bundle;
                if (bus.start) begin
                    state_nxt = WAIT;
                end else if (last_pix) begin
                    if (last_bundle)       state_nxt = IDLE;
                    else if (bus.in_valid) state_nxt = WRITE;
                    else                   state_nxt = WAIT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_k          <= '0;
            bundle_cnt     <= '0;
            addr_ptr       <= '0;
            cap_0          <= '0;
            cap_1          <= '0;
            cap_2          <= '0;
            cap_3          <= '0;
            done_pend      <= 1'b0;
            bus.sram_we    <= 1'b0;
            bus.sram_addr  <= '0;
            bus.sram_wdata <= '0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.sram_we    <= 1'b0;
            bus.frame_done <= done_pend;
            done_pend      <= 1'b0;
            if (bus.start) begin
                addr_ptr   <= bus.base_addr;
                bundle_cnt <= '0;
                pix_k      <= '0;
                bus.busy   <= 1'b1;
            end else begin
                if (done_pend) bus.busy <= 1'b0;
                if (handshake) begin
                    cap_0 <= bus.denoise_block_out_0;
                    cap_1 <= bus.denoise_block_out_1;
                    cap_2 <= bus.denoise_block_out_2;
                    cap_3 <= bus.denoise_block_out_3;
                    pix_k <= '0;
                end
                // Each WRITE cycle registers one packed pixel; frame_done trails the last one.
                if (state == WRITE) begin
                    bus.sram_we    <= 1'b1;
                    bus.sram_addr  <= addr_ptr;
                    bus.sram_wdata <= {cap_3[int'(pix_k)*BITWIDTH +: BITWIDTH],
                                       cap_2[int'(pix_k)*BITWIDTH +: BITWIDTH],
                                       cap_1[int'(pix_k)*BITWIDTH +: BITWIDTH],
                                       cap_0[int'(pix_k)*BITWIDTH +: BITWIDTH]};
                    addr_ptr       <= addr_ptr + ADDR_W'(1);
                    if (last_pix) begin
                        if (last_bundle) done_pend  <= 1'b1;
                        else             bundle_cnt <= bundle_cnt + CNT_W'(1);
                    end else begin
                        pix_k <= pix_k + 4'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_denoise_writeback.sv
// Randomized scoreboard bench for denoise_writeback: a transaction-level model predicts
// the write stream, handshake window, busy and frame_done; a monitor compares each cycle.
module tb_denoise_writeback;
    localparam int BW    = 8;
    localparam int AW    = 5;
    localparam int NB    = 3;
    localparam int BLK_W = BW * 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    denoise_writeback_if #(.BITWIDTH(BW), .ADDR_W(AW)) bus ();

    denoise_writeback #(.BITWIDTH(BW), .ADDR_W(AW), .NUM_BUNDLE(NB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [AW-1:0]   addr;
        logic [4*BW-1:0] data;
    } wr_t;

    int checks = 0;
    int errors = 0;

    wr_t           exp_q[$];
    bit            active;
    bit            exp_we;
    bit            exp_done;
    bit            pend;
    bit            exp_busy;
    int            remain;
    int            accepted;
    logic [AW-1:0] next_addr;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return active && (remain <= 1) && (accepted < NB);
    endfunction

    // Pixel k of each block, packed with block 0 in the low byte.
    function automatic logic [4*BW-1:0] pixel_word(input logic [BLK_W-1:0] b0, input logic [BLK_W-1:0] b1,
                                                    input logic [BLK_W-1:0] b2, input logic [BLK_W-1:0] b3,
                                                    input int k);
        logic [BLK_W-1:0] blks[4];
        logic [4*BW-1:0]  w;
        blks[0] = b0; blks[1] = b1; blks[2] = b2; blks[3] = b3;
        w = '0;
        for (int n = 0; n < 4; n++) begin
            w = w | ((4*BW)'((blks[n] >> (BW * k)) & BLK_W'(8'hFF)) << (BW * n));
        end
        return w;
    endfunction

    // Model: an accepted bundle owes nine writes at consecutive addresses, one per cycle.
    always @(posedge clk or negedge rst_n) begin : ref_model
        bit  hs;
        bit  issue;
        wr_t w;
        if (!rst_n) begin
            exp_q.delete();
            active = 0; exp_we = 0; exp_done = 0; pend = 0; exp_busy = 0;
            remain = 0; accepted = 0; next_addr = '0;
        end else begin
            hs       = model_ready() && bus.in_valid && !bus.start;
            issue    = (remain > 0) && !bus.start;
            exp_done = pend;
            pend     = issue && (remain == 1) && (accepted == NB);
            exp_we   = issue;
            if (bus.start) begin
                exp_q.delete();
                active    = 1;
                accepted  = 0;
                remain    = 0;
                next_addr = bus.base_addr;
                exp_busy  = 1;
            end else begin
                if (exp_done) exp_busy = 0;
                if (remain > 0) remain--;
                if (hs) begin
                    for (int k = 0; k < 9; k++) begin
                        w.addr = next_addr + AW'(k);
                        w.data = pixel_word(bus.denoise_block_out_0, bus.denoise_block_out_1,
                                            bus.denoise_block_out_2, bus.denoise_block_out_3, k);
                        exp_q.push_back(w);
                    end
                    next_addr = next_addr + AW'(9);
                    accepted++;
                    remain = 9;
                end
                if (accepted == NB && remain == 0) active = 0;
            end
        end
    end

    always @(negedge clk) begin : monitor
        wr_t got;
        checkOutput("sram_we", 64'(bus.sram_we), 64'(exp_we));
        checkOutput("frame_done", 64'(bus.frame_done), 64'(exp_done));
        checkOutput("busy", 64'(bus.busy), 64'(exp_busy));
        checkOutput("in_ready", 64'(bus.in_ready), 64'(model_ready()));
        if (!rst_n) begin
            checkOutput("reset_addr", 64'(bus.sram_addr), 64'(0));
            checkOutput("reset_wdata", 64'(bus.sram_wdata), 64'(0));
        end else if (bus.sram_we) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_write", 64'(bus.sram_addr), 64'(0) - 64'(1));
            end else begin
                got = exp_q.pop_front();
                checkOutput("sram_addr", 64'(bus.sram_addr), 64'(got.addr));
                checkOutput("sram_wdata", 64'(bus.sram_wdata), 64'(got.data));
            end
        end
    end

    task automatic set_blocks(input bit pattern);
        logic [BLK_W-1:0] b[4];
        for (int n = 0; n < 4; n++) begin
            if (pattern) begin
                for (int k = 0; k < 9; k++) b[n][k*BW +: BW] = BW'(16 * n + k);
            end else begin
                b[n] = BLK_W'({$urandom(), $urandom(), $urandom()});
            end
        end
        bus.denoise_block_out_0 = b[0];
        bus.denoise_block_out_1 = b[1];
        bus.denoise_block_out_2 = b[2];
        bus.denoise_block_out_3 = b[3];
    endtask

    // Offers the bundle on the bus until accepted, then idles in_valid for gap cycles.
    task automatic applyStimulus(input int gap);
        bit ok;
        ok = 0;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            ok = bus.in_ready && !bus.start;
            @(posedge clk);
            #1;
        end
        checkOutput("handshake_timeout", 64'(ok), 64'(1));
        if (gap > 0) begin
            bus.in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] base);
        bus.start     = 1'b1;
        bus.base_addr = base;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.base_addr = AW'($urandom());
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 100 && bus.busy; n++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("frame_timeout", 64'(bus.busy), 64'(0));
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [AW-1:0] base, input int gap, input bit rand_gap, input bit pattern);
        pulse_start(base);
        for (int b = 0; b < NB; b++) begin
            set_blocks(pattern && b == 0);
            applyStimulus(rand_gap ? int'($urandom_range(0, 4)) : gap);
        end
        wait_idle();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.in_valid = 1'b0;
        set_blocks(1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] single-pattern and back-to-back frame");
        run_frame(AW'(5'h10), 0, 1'b0, 1'b1);
        $display("[TB] stalled upstream");
        run_frame(AW'($urandom()), 5, 1'b0, 1'b0);
        $display("[TB] address wrap");
        run_frame(AW'(5'h1C), 0, 1'b0, 1'b0);

        $display("[TB] abort mid-bundle");
        pulse_start(AW'(5'h03));
        set_blocks(1'b0);
        applyStimulus(0);
        set_blocks(1'b0);
        applyStimulus(0);
        set_blocks(1'b0);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.base_addr = AW'(5'h15);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        set_blocks(1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        set_blocks(1'b0);
        for (int b = 0; b < NB; b++) begin
            set_blocks(1'b0);
            applyStimulus(0);
        end
        wait_idle();

        $display("[TB] async reset mid-write");
        pulse_start(AW'($urandom()));
        set_blocks(1'b0);
        applyStimulus(0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_we", 64'(bus.sram_we), 64'(0));
        checkOutput("arst_addr", 64'(bus.sram_addr), 64'(0));
        checkOutput("arst_wdata", 64'(bus.sram_wdata), 64'(0));
        checkOutput("arst_busy", 64'(bus.busy), 64'(0));
        checkOutput("arst_ready", 64'(bus.in_ready), 64'(0));
        checkOutput("arst_done", 64'(bus.frame_done), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;

        $display("[TB] random frames");
        for (int f = 0; f < 4; f++) begin
            run_frame(AW'($urandom()), 0, 1'b1, 1'b0);
        end

        repeat (5) @(posedge clk);
        #1;
        checkOutput("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/denoise_writeback.md
# denoise_writeback

Downstream of the median/Gaussian output selector: accepts one bundle of four denoised 3x3 blocks per handshake and serializes it into nine 32-bit SRAM writes. Each write carries the same pixel index from all four blocks. The block counts bundles per frame and signals completion so the top-level controller can advance to the next frame.

## Interface
- BITWIDTH, 8, bits per pixel
- ADDR_W, 10, SRAM address width
- NUM_BUNDLE, 64, bundles per frame (≥1)

- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse: begin/restart a frame
- base_addr  input  ADDR_W  first write address, sampled when start=1
- in_valid  input  1  bundle on denoise_block_out_* is valid
- in_ready  output  1  block can accept a bundle this cycle
- denoise_block_out_0..3  input  BITWIDTH*9 each  selected denoised blocks; pixel k at bits [BITWIDTH*(k+1)-1 : BITWIDTH*k]
- sram_we  output  1  active-high write strobe
- sram_addr  output  ADDR_W  write address
- sram_wdata  output  BITWIDTH*4  {blk3[k], blk2[k], blk1[k], blk0[k]}
- busy  output  1  high from start until frame_done
- frame_done  output  1  one-cycle pulse after the last write of a frame

## Operation
- States: IDLE, WAIT, WRITE.
- IDLE: in_ready=0 and busy=0. start → WAIT. Also load addr_ptr=base_addr and bundle_cnt=0.
- WAIT: in_ready=1. in_valid&in_ready → capture all four blocks, set k=0, go to WRITE.
- WRITE: for k=0..8, one cycle each, register sram_we=1, sram_addr=addr_ptr, and sram_wdata=pixel k of captured blocks. Then addr_ptr++.
- At k=8:
  - If bundle_cnt==NUM_BUNDLE-1 → IDLE. frame_done=1 next cycle.
  - Otherwise bundle_cnt++. in_ready=1 during this cycle so back-to-back bundles are possible.
  - If a handshake occurs at k=8, capture the new bundle and restart at k=0 in WRITE.
  - Without a handshake → WAIT.
- addr_ptr wraps modulo 2^ADDR_W with no error flag.
- bundle_cnt width is $clog2(NUM_BUNDLE+1).
- start in WAIT or WRITE aborts the frame:
  - The captured bundle is dropped.
  - Counters and address are reloaded and the state goes to WAIT.
  - sram_we is 0 on the next cycle.
  - No frame_done is generated.
- start has priority over a simultaneous handshake; that bundle is not accepted.
- in_valid is ignored when in_ready=0. Upstream must hold its data until the handshake.
- The capture register is the only storage; no data is sampled outside the handshake.

## Timing
- Reset values: state IDLE, in_ready 0, sram_we 0, sram_addr 0, sram_wdata 0, busy 0, frame_done 0, internal counters 0.
- Reset mid-frame drops everything immediately and asynchronously. No writes occur until the next start.
- in_ready and busy are decoded from registered state, so neither has a combinational path from in_valid.
- Write latency: with the handshake at edge E, the k=0 write is visible in the cycle after E, and k=8 in the 9th cycle after E.
- Sustained throughput is 1 bundle per 9 cycles and sram_we stays high continuously. A gap in in_valid inserts idle write cycles.
- frame_done goes high in the cycle after the final sram_we cycle. busy falls in that same cycle.
- start is sampled on the edge. busy is 1 from the next cycle.

## Test plan
- **Single-bundle frame.** NUM_BUNDLE=1, base_addr=0x010, blk_n pixel k = 16n+k, handshake at edge E.
  - Writes to addresses 0x010..0x018 in cycles E+1..E+9.
  - Write k has wdata {0x30+k, 0x20+k, 0x10+k, 0x00+k}.
  - frame_done pulses in cycle E+10.
- **Back-to-back bundles.** NUM_BUNDLE=4, in_valid held high.
  - sram_we is high for 36 consecutive cycles at addresses base..base+35.
  - in_ready is high only on each k=8 cycle.
  - A single frame_done follows the last write.
- **Stalled upstream.** in_valid dropped for 5 cycles between bundles.
  - in_ready stays 1 in WAIT and sram_we is 0 for those cycles.
  - Address continuity is preserved and no data is lost or duplicated.
- **Address wrap.** ADDR_W=4, base_addr=0xC, NUM_BUNDLE=1.
  - Addresses are 0xC,0xD,0xE,0xF,0x0..0x4.
- **Abort.** start pulsed at k=4 of bundle 2.
  - sram_we is 0 on the next cycle and there is no frame_done.
  - The next accepted bundle writes from the new base_addr with bundle_cnt=0.
  - A handshake coinciding with start is not accepted.
- **Async reset.** rst_n pulled low mid-WRITE.
  - All outputs go to 0 immediately.
  - After release, no activity occurs until start.
